spi_midi_decoder: RTL

//  Consumes the byte stream from the SPI receive stage and parses it as MIDI-style

---
 rtl/spi_midi_decoder_pkg.sv | 30 +++
 rtl/spi_midi_decoder_if.sv | 24 ++
 rtl/spi_midi_decoder_timeout.sv | 39 +++
 rtl/spi_midi_decoder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_midi_decoder_pkg.sv
// ----------------------------------------------------------------------------
// spi_midi_decoder_pkg
//   Shared constants and types for the MIDI channel-message decoder.
//   - Status nibbles for the three supported channel messages
//   - Threshold above which a byte is a real-time message
//   - Parser FSM state type
//   - isVoiceStatus(): true for a status byte that starts a supported message
// ----------------------------------------------------------------------------
package spi_midi_decoder_pkg;

    localparam logic [3:0] NOTE_OFF     = 4'h8;
    localparam logic [3:0] NOTE_ON      = 4'h9;
    localparam logic [3:0] CC           = 4'hB;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_D1,
        WAIT_D2,
        EMIT
    } midiState_e;

    // Only Note Off, Note On and Control Change establish running status.
    function automatic logic isVoiceStatus(input logic [7:0] statusByte);
        return (statusByte[7:4] == NOTE_OFF) ||
               (statusByte[7:4] == NOTE_ON)  ||
               (statusByte[7:4] == CC);
    endfunction

endpackage

// File: rtl/spi_midi_decoder_if.sv
// ----------------------------------------------------------------------------
// spi_midi_decoder_if
//   Byte stream from the SPI receive stage into the MIDI decoder.
//   i_byte        : received byte
//   i_byte_valid  : one-cycle strobe, i_byte is new this cycle
//   master modport: the SPI receive stage (drives the stream)
//   slave modport : the decoder (consumes the stream)
// ----------------------------------------------------------------------------
interface spi_midi_decoder_if;

    logic [7:0] i_byte;
    logic       i_byte_valid;

    modport master (
        output i_byte,
        output i_byte_valid
    );

    modport slave (
        input i_byte,
        input i_byte_valid
    );

endinterface

// File: rtl/spi_midi_decoder_timeout.sv
// ----------------------------------------------------------------------------
// msg_timeout_counter
//   Saturating inter-byte timer for a partially received message.
//   clk_i      : system clock
//   rstN_i     : asynchronous active-low reset
//   clear_i    : restart the count (a byte was accepted)
//   enable_i   : count this cycle (a message is in progress)
//   expired_o  : count has reached P_TIMEOUT; stays high until cleared
// ----------------------------------------------------------------------------
module msg_timeout_counter #(
    parameter int P_TIMEOUT = 50000
) (
    input  logic clk_i,
    input  logic rstN_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(P_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(P_TIMEOUT);

    logic [CNT_W-1:0] count_q;

    // Count idle cycles while enabled; park at the limit instead of wrapping
    // so a long silence can never look like a fresh message.
    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired_o = (count_q == CNT_MAX);

endmodule

// File: rtl/spi_midi_decoder.sv
// ----------------------------------------------------------------------------
// spi_midi_decoder
//   Parses the SPI byte stream as MIDI channel messages (Note On, Note Off,
//   Control Change) with running status, and drives event pulses plus a mono
//   gate for the voice/envelope stages.
//   i_sys_clk / i_rst_n : system clock, asynchronous active-low reset
//   byte_if (slave)     : i_byte / i_byte_valid byte stream
//   o_note_on/o_note_off: one-cycle note event pulses
//   o_note/o_velocity   : data of the last note event
//   o_cc_valid          : one-cycle control change pulse
//   o_cc_num/o_cc_val   : data of the last control change
//   o_channel           : channel of the last emitted event
//   o_gate              : high while the most recent note-on note is held
// ----------------------------------------------------------------------------
module spi_midi_decoder
    import spi_midi_decoder_pkg::*;
#(
    parameter logic [3:0] P_CHANNEL = 4'd0,
    parameter bit         P_OMNI    = 1'b1,
    parameter int         P_TIMEOUT = 50000
) (
    input  logic                     i_sys_clk,
    input  logic                     i_rst_n,
    spi_midi_decoder_if.slave        byte_if,
    output logic                     o_note_on,
    output logic                     o_note_off,
    output logic [6:0]               o_note,
    output logic [6:0]               o_velocity,
    output logic                     o_cc_valid,
    output logic [6:0]               o_cc_num,
    output logic [6:0]               o_cc_val,
    output logic [3:0]               o_channel,
    output logic                     o_gate
);

    midiState_e state_q, state_d;
    logic [7:0] runStatus_q, runStatus_d;
    logic       runValid_q, runValid_d;
    logic [6:0] data1_q, data1_d;
    logic [6:0] gateNote_q, gateNote_d;
    logic       noteOn_q, noteOn_d;
    logic       noteOff_q, noteOff_d;
    logic [6:0] note_q, note_d;
    logic [6:0] velocity_q, velocity_d;
    logic       ccValid_q, ccValid_d;
    logic [6:0] ccNum_q, ccNum_d;
    logic [6:0] ccVal_q, ccVal_d;
    logic [3:0] channel_q, channel_d;
    logic       gate_q, gate_d;

    logic [6:0] dataByte;
    logic       isStatus;
    logic       isRealtime;
    logic       byteAccept;
    logic [3:0] msgType;
    logic [3:0] msgChan;
    logic       chanOk;
    logic       isNoteOnMsg;
    logic       isNoteOffMsg;
    logic       isCcMsg;
    logic       timeoutExpired;

    assign dataByte   = byte_if.i_byte[6:0];
    assign isStatus   = byte_if.i_byte[7];
    assign isRealtime = (byte_if.i_byte >= REALTIME_MIN);
    // Real-time bytes are invisible: they neither advance the parser nor
    // restart the inter-byte timer.
    assign byteAccept = byte_if.i_byte_valid && !isRealtime;

    assign msgType      = runStatus_q[7:4];
    assign msgChan      = runStatus_q[3:0];
    assign chanOk       = P_OMNI || (msgChan == P_CHANNEL);
    // A Note On with zero velocity is a note off by MIDI convention.
    assign isNoteOnMsg  = (msgType == NOTE_ON) && (dataByte != 7'd0);
    assign isNoteOffMsg = (msgType == NOTE_OFF) ||
                          ((msgType == NOTE_ON) && (dataByte == 7'd0));
    assign isCcMsg      = (msgType == CC);

    // The timer only runs while the second data byte is outstanding; a
    // stalled WAIT_D1 already has nothing partial to throw away.
    msg_timeout_counter #(
        .P_TIMEOUT (P_TIMEOUT)
    ) u_timeout (
        .clk_i     (i_sys_clk),
        .rstN_i    (i_rst_n),
        .clear_i   (byteAccept),
        .enable_i  (state_q == WAIT_D2),
        .expired_o (timeoutExpired)
    );

    // State and output registers. Event data is registered on the same edge
    // that strobes the second data byte, so events show up one cycle later
    // while the FSM sits in EMIT.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            runStatus_q <= 8'd0;
            runValid_q  <= 1'b0;
            data1_q     <= 7'd0;
            gateNote_q  <= 7'd0;
            noteOn_q    <= 1'b0;
            noteOff_q   <= 1'b0;
            note_q      <= 7'd0;
            velocity_q  <= 7'd0;
            ccValid_q   <= 1'b0;
            ccNum_q     <= 7'd0;
            ccVal_q     <= 7'd0;
            channel_q   <= 4'd0;
            gate_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            runStatus_q <= runStatus_d;
            runValid_q  <= runValid_d;
            data1_q     <= data1_d;
            gateNote_q  <= gateNote_d;
            noteOn_q    <= noteOn_d;
            noteOff_q   <= noteOff_d;
            note_q      <= note_d;
            velocity_q  <= velocity_d;
            ccValid_q   <= ccValid_d;
            ccNum_q     <= ccNum_d;
            ccVal_q     <= ccVal_d;
            channel_q   <= channel_d;
            gate_q      <= gate_d;
        end
    end

    // Parser: status bytes always take effect immediately (discarding any
    // partial message); data bytes only count once a supported running
    // status exists. EMIT behaves like WAIT_D1 for an incoming byte so that
    // back-to-back running-status messages are not lost.
    always_comb begin
        state_d     = state_q;
        runStatus_d = runStatus_q;
        runValid_d  = runValid_q;
        data1_d     = data1_q;
        gateNote_d  = gateNote_q;
        noteOn_d    = 1'b0;
        noteOff_d   = 1'b0;
        note_d      = note_q;
        velocity_d  = velocity_q;
        ccValid_d   = 1'b0;
        ccNum_d     = ccNum_q;
        ccVal_d     = ccVal_q;
        channel_d   = channel_q;
        gate_d      = gate_q;

        if (byteAccept) begin
            if (isStatus) begin
                if (isVoiceStatus(byte_if.i_byte)) begin
                    runStatus_d = byte_if.i_byte;
                    runValid_d  = 1'b1;
                    state_d     = WAIT_D1;
                end else begin
                    runValid_d  = 1'b0;
                    state_d     = IDLE;
                end
            end else if (runValid_q && (state_q != IDLE)) begin
                if (state_q == WAIT_D2) begin
                    state_d = EMIT;
                    // Filtered channels are still parsed so running status
                    // stays in step; they just produce nothing.
                    if (chanOk) begin
                        if (isNoteOnMsg) begin
                            noteOn_d   = 1'b1;
                            note_d     = data1_q;
                            velocity_d = dataByte;
                            channel_d  = msgChan;
                            gate_d     = 1'b1;
                            gateNote_d = data1_q;
                        end else if (isNoteOffMsg) begin
                            noteOff_d  = 1'b1;
                            note_d     = data1_q;
                            velocity_d = dataByte;
                            channel_d  = msgChan;
                            // Last-note priority: releasing an older note
                            // must not cut the one currently sounding.
                            if (data1_q == gateNote_q) begin
                                gate_d = 1'b0;
                            end
                        end else if (isCcMsg) begin
                            ccValid_d  = 1'b1;
                            ccNum_d    = data1_q;
                            ccVal_d    = dataByte;
                            channel_d  = msgChan;
                        end
                    end
                end else begin
                    data1_d = dataByte;
                    state_d = WAIT_D2;
                end
            end
        end else if ((state_q == EMIT) ||
                     ((state_q == WAIT_D2) && timeoutExpired)) begin
            state_d = WAIT_D1;
        end
    end

    assign o_note_on  = noteOn_q;
    assign o_note_off = noteOff_q;
    assign o_note     = note_q;
    assign o_velocity = velocity_q;
    assign o_cc_valid = ccValid_q;
    assign o_cc_num   = ccNum_q;
    assign o_cc_val   = ccVal_q;
    assign o_channel  = channel_q;
    assign o_gate     = gate_q;

endmodule
